// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch, decode and dispatch handshake of the instruction queue.
// The master side is the surrounding pipeline; the queue itself uses the slave side.
interface inst_queue_if;
    logic        rdy_in;
    logic        inst_valid_if_in;
    logic [31:0] inst_if_in;
    logic [31:0] pc_if_in;
    logic        full_if_out;
    logic        rdy_dc_out;
    logic [31:0] inst_dc_out;
    logic [31:0] pc_dc_out;
    logic        stall_dp_in;
    logic        clear_in;
    modport master (
        output rdy_in, inst_valid_if_in, inst_if_in, pc_if_in, stall_dp_in, clear_in,
        input  full_if_out, rdy_dc_out, inst_dc_out, pc_dc_out
    );
    modport slave (
        input  rdy_in, inst_valid_if_in, inst_if_in, pc_if_in, stall_dp_in, clear_in,
        output full_if_out, rdy_dc_out, inst_dc_out, pc_dc_out
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: show-ahead FIFO of fetched instructions feeding the decoder.
// Flushed by clear_in and frozen while rdy_in is low.
module inst_queue #(
    parameter int DEPTH_LOG         = 4,
    parameter int ALMOST_FULL_SLACK = 1
) (
    input logic         clk_in,
    input logic         rst_in,
    inst_queue_if.slave q
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] CNT_MAX  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG + 1)'(DEPTH - ALMOST_FULL_SLACK);
    logic [31:0]          inst_mem [DEPTH];
    logic [31:0]          pc_mem   [DEPTH];
    logic [DEPTH_LOG-1:0] head, tail;
    logic [DEPTH_LOG:0]   count;
    logic                 live, nonempty, push, pop;
    always_comb begin
        live          = q.rdy_in && !q.clear_in;
        nonempty      = count != '0;
        push          = live && q.inst_valid_if_in && count < CNT_MAX;
        pop           = live && nonempty && !q.stall_dp_in;
        q.rdy_dc_out  = live && nonempty;
        q.inst_dc_out = nonempty ? inst_mem[head] : '0;
        q.pc_dc_out   = nonempty ? pc_mem[head] : '0;
        q.full_if_out = count >= CNT_FULL;
    end
    // A full queue drops pushes even when the head pops in the same cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.rdy_in) begin
            if (q.clear_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + DEPTH_LOG'(1);
                if (pop) head <= head + DEPTH_LOG'(1);
                count <= count + (DEPTH_LOG + 1)'(push) - (DEPTH_LOG + 1)'(pop);
            end
        end
    end
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail] <= q.inst_if_in;
            pc_mem[tail]   <= q.pc_if_in;
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and randomized checks of inst_queue against a queue-based model.
module tb_inst_queue;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [63:0] mq[$];
    logic last_push = 1'b0;

    inst_queue_if q();
    inst_queue dut (.clk_in(clk_in), .rst_in(rst_in), .q(q));

    always #5 clk_in = ~clk_in;

    function automatic logic m_rdy();
        return q.rdy_in && !q.clear_in && mq.size() != 0;
    endfunction
    function automatic logic [31:0] m_inst();
        return mq.size() != 0 ? mq[0][63:32] : 32'd0;
    endfunction
    function automatic logic [31:0] m_pc();
        return mq.size() != 0 ? mq[0][31:0] : 32'd0;
    endfunction
    function automatic logic m_full();
        return mq.size() >= 15;
    endfunction

    // Advance the model with the inputs currently driven, then clock once.
    task automatic tick();
        logic pu, po;
        po = m_rdy() && !q.stall_dp_in;
        pu = q.rdy_in && !q.clear_in && q.inst_valid_if_in && mq.size() < 16;
        last_push = pu;
        if (q.rdy_in && q.clear_in) mq.delete();
        else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back({q.inst_if_in, q.pc_if_in});
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        q.rdy_in = 1; q.inst_valid_if_in = 0; q.inst_if_in = 0; q.pc_if_in = 0;
        q.stall_dp_in = 1; q.clear_in = 0;
        @(posedge clk_in);
        #1;
        rst_in = 0;
        mq.delete();
        #1;
        checks++; if (q.rdy_dc_out !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", q.rdy_dc_out); end
        checks++; if (q.inst_dc_out !== 32'd0) begin errors++; $display("FAIL reset_inst got=%h exp=0", q.inst_dc_out); end
        checks++; if (q.pc_dc_out !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", q.pc_dc_out); end
        checks++; if (q.full_if_out !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", q.full_if_out); end
    endtask

    task automatic test_show_ahead();
        logic [31:0] insts [3];
        insts = '{32'h00000013, 32'h00100093, 32'h00200113};
        q.stall_dp_in = 1;
        for (int i = 0; i < 3; i++) begin
            q.inst_valid_if_in = 1; q.inst_if_in = insts[i]; q.pc_if_in = 32'(4 * i);
            #1;
            if (i == 0) begin
                checks++; if (q.rdy_dc_out !== 1'b0) begin errors++; $display("FAIL no_fallthrough rdy got=%b exp=0", q.rdy_dc_out); end
            end else begin
                checks++;
                if (q.rdy_dc_out !== 1'b1 || q.inst_dc_out !== 32'h13 || q.pc_dc_out !== 32'h0) begin
                    errors++; $display("FAIL stalled_head rdy=%b inst=%h pc=%h exp 1/00000013/0", q.rdy_dc_out, q.inst_dc_out, q.pc_dc_out);
                end
            end
            tick();
        end
        q.inst_valid_if_in = 0;
        q.stall_dp_in = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q.rdy_dc_out !== 1'b1 || q.inst_dc_out !== insts[i] || q.pc_dc_out !== 32'(4 * i)) begin
                errors++; $display("FAIL drain_step%0d rdy=%b inst=%h pc=%h exp 1/%h/%h", i, q.rdy_dc_out, q.inst_dc_out, q.pc_dc_out, insts[i], 4 * i);
            end
            tick();
        end
        #1;
        checks++;
        if (q.rdy_dc_out !== 1'b0 || q.inst_dc_out !== 32'd0) begin
            errors++; $display("FAIL drained_empty rdy=%b inst=%h exp 0/0", q.rdy_dc_out, q.inst_dc_out);
        end
    endtask

    task automatic test_fill();
        q.stall_dp_in = 1;
        for (int i = 0; i < 17; i++) begin
            q.inst_valid_if_in = 1; q.inst_if_in = $urandom; q.pc_if_in = 32'h100 + 32'(4 * i);
            #1;
            checks++;
            if (q.full_if_out !== (i >= 15)) begin
                errors++; $display("FAIL full_flag at %0d entries got=%b exp=%b", i, q.full_if_out, i >= 15);
            end
            tick();
        end
        q.inst_valid_if_in = 0;
        #1;
        checks++;
        if (q.pc_dc_out !== 32'h100 || q.inst_dc_out !== m_inst() || q.full_if_out !== 1'b1) begin
            errors++; $display("FAIL overflow_head pc=%h inst=%h full=%b exp 00000100/%h/1", q.pc_dc_out, q.inst_dc_out, q.full_if_out, m_inst());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] next_pc, exp_pop;
        next_pc = 32'h140;
        exp_pop = 32'h100;
        q.stall_dp_in = 0;
        q.inst_valid_if_in = 1;
        for (int c = 0; c < 40; c++) begin
            q.pc_if_in = next_pc; q.inst_if_in = ~next_pc;
            #1;
            checks++;
            if (q.rdy_dc_out !== 1'b1 || q.pc_dc_out !== exp_pop || q.inst_dc_out !== m_inst()) begin
                errors++; $display("FAIL wrap_order c=%0d rdy=%b pc=%h inst=%h exp 1/%h/%h", c, q.rdy_dc_out, q.pc_dc_out, q.inst_dc_out, exp_pop, m_inst());
            end
            exp_pop += 4;
            tick();
            if (last_push) next_pc += 4;
        end
        q.inst_valid_if_in = 0;
        for (int c = 0; c < 20 && mq.size() != 0; c++) begin
            #1;
            checks++;
            if (q.pc_dc_out !== exp_pop) begin
                errors++; $display("FAIL wrap_drain c=%0d pc=%h exp=%h", c, q.pc_dc_out, exp_pop);
            end
            exp_pop += 4;
            tick();
        end
        #1;
        checks++; if (q.rdy_dc_out !== 1'b0) begin errors++; $display("FAIL wrap_empty rdy got=%b exp=0", q.rdy_dc_out); end
    endtask

    task automatic test_clear();
        q.stall_dp_in = 1;
        for (int i = 0; i < 5; i++) begin
            q.inst_valid_if_in = 1; q.inst_if_in = $urandom; q.pc_if_in = 32'h200 + 32'(4 * i);
            tick();
        end
        q.clear_in = 1; q.inst_if_in = 32'hdeadbeef; q.pc_if_in = 32'h2fc;
        #1;
        checks++; if (q.rdy_dc_out !== 1'b0) begin errors++; $display("FAIL clear_same_cycle rdy got=%b exp=0", q.rdy_dc_out); end
        tick();
        q.clear_in = 0; q.inst_valid_if_in = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (q.rdy_dc_out !== 1'b0 || q.inst_dc_out !== 32'd0 || q.pc_dc_out !== 32'd0) begin
                errors++; $display("FAIL clear_after c=%0d rdy=%b inst=%h pc=%h exp 0/0/0", c, q.rdy_dc_out, q.inst_dc_out, q.pc_dc_out);
            end
            tick();
        end
    endtask

    task automatic test_rdy_reset();
        q.stall_dp_in = 1;
        for (int i = 0; i < 4; i++) begin
            q.inst_valid_if_in = 1; q.inst_if_in = $urandom; q.pc_if_in = 32'h300 + 32'(4 * i);
            tick();
        end
        q.rdy_in = 0; q.stall_dp_in = 0; q.pc_if_in = 32'h999;
        for (int c = 0; c < 3; c++) begin
            q.clear_in = c == 2;
            #1;
            checks++;
            if (q.rdy_dc_out !== 1'b0 || q.full_if_out !== 1'b0) begin
                errors++; $display("FAIL frozen c=%0d rdy=%b full=%b exp 0/0", c, q.rdy_dc_out, q.full_if_out);
            end
            tick();
        end
        q.rdy_in = 1; q.clear_in = 0; q.inst_valid_if_in = 0; q.stall_dp_in = 1;
        #1;
        checks++;
        if (q.rdy_dc_out !== 1'b1 || q.pc_dc_out !== 32'h300) begin
            errors++; $display("FAIL thawed_head rdy=%b pc=%h exp 1/00000300", q.rdy_dc_out, q.pc_dc_out);
        end
        #1;
        rst_in = 1;
        mq.delete();
        #1;
        checks++;
        if (q.rdy_dc_out !== 1'b0 || q.inst_dc_out !== 32'd0 || q.pc_dc_out !== 32'd0 || q.full_if_out !== 1'b0) begin
            errors++; $display("FAIL async_reset rdy=%b inst=%h pc=%h full=%b exp all 0", q.rdy_dc_out, q.inst_dc_out, q.pc_dc_out, q.full_if_out);
        end
        #1;
        rst_in = 0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            q.rdy_in = $urandom_range(0, 9) != 0;
            q.clear_in = $urandom_range(0, 24) == 0;
            q.inst_valid_if_in = $urandom_range(0, 2) != 0;
            q.stall_dp_in = $urandom_range(0, 2) == 0;
            q.inst_if_in = $urandom; q.pc_if_in = $urandom;
            #1;
            checks++;
            if (q.rdy_dc_out !== m_rdy() || q.inst_dc_out !== m_inst() || q.pc_dc_out !== m_pc() || q.full_if_out !== m_full()) begin
                errors++;
                $display("FAIL random c=%0d rdy=%b inst=%h pc=%h full=%b exp %b/%h/%h/%b", c, q.rdy_dc_out, q.inst_dc_out, q.pc_dc_out, q.full_if_out, m_rdy(), m_inst(), m_pc(), m_full());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_show_ahead();
        test_fill();
        test_wrap();
        test_clear();
        test_rdy_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
